result_checker: RTL

- Hardware reader/checker for the output SRAM that the compute core writes.
- After a run, it reads back N result words and the matching golden words, one word per cycle from each of two SRAM read ports.
- It counts matches and mismatches, captures the first mismatch address, and reports pass/fail.
- It uses the same run/busy handshake as the compute core, so the same top-level sequencer can drive either block.

---
 rtl/result_checker.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/result_checker.sv
// -----------------------------------------------------------------------------
// result_checker
//
// Reads back N result words from the output SRAM together with the matching
// golden words (one word per cycle from each of two read ports), counts
// matches and mismatches, records the address of the first mismatch and
// reports pass/fail. It uses the same run/busy handshake as the compute core
// so one top-level sequencer can drive either block.
//
// Handshake (run/busy):
//   A check starts only on a rising edge of chk_run seen while IDLE. chk_busy
//   rises the cycle after that edge and stays high for N+1 cycles (N reads
//   plus one drain cycle). chk_done then pulses for exactly one cycle with
//   chk_busy low; results are valid from chk_done onward and hold until the
//   next start. chk_run is ignored while a check is in progress, and holding
//   it high never retriggers. N=0 skips straight to the done pulse.
//
// Ports:
//   clk                       rising-edge clock
//   reset_b                   asynchronous active-low reset
//   chk_run                   start request (rising edge only)
//   chk_busy                  check in progress
//   chk_num_results           N, sampled at start
//   chk_res_read_address      result SRAM read address
//   res_chk_read_data         result SRAM data, 1 cycle after its address
//   chk_gold_read_address     golden SRAM read address (= result address)
//   gold_chk_read_data        golden SRAM data, 1 cycle after its address
//   chk_correct_count         number of matching words
//   chk_mismatch_count        number of mismatching words
//   chk_first_mismatch_addr   address of the first mismatch
//   chk_first_mismatch_valid  a mismatch has been recorded
//   chk_done                  one-cycle completion pulse
//   chk_pass                  last check had no mismatches
//   chk_dbg_state             current FSM state (debug observation)
// -----------------------------------------------------------------------------
module result_checker #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 13
) (
   input  logic                  clk,
   input  logic                  reset_b,
   input  logic                  chk_run,
   output logic                  chk_busy,
   input  logic [ADDR_WIDTH-1:0] chk_num_results,
   output logic [ADDR_WIDTH-1:0] chk_res_read_address,
   input  logic [DATA_WIDTH-1:0] res_chk_read_data,
   output logic [ADDR_WIDTH-1:0] chk_gold_read_address,
   input  logic [DATA_WIDTH-1:0] gold_chk_read_data,
   output logic [CNT_WIDTH-1:0]  chk_correct_count,
   output logic [CNT_WIDTH-1:0]  chk_mismatch_count,
   output logic [ADDR_WIDTH-1:0] chk_first_mismatch_addr,
   output logic                  chk_first_mismatch_valid,
   output logic                  chk_done,
   output logic                  chk_pass,
   output logic [1:0]            chk_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] A_ZERO = '0;
   localparam logic [ADDR_WIDTH-1:0] A_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0]  C_ZERO = '0;
   localparam logic [CNT_WIDTH-1:0]  C_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                r_state;
   logic                  r_run_q;
   logic [ADDR_WIDTH-1:0] r_num;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_cmp_valid;
   logic [ADDR_WIDTH-1:0] r_cmp_addr;
   logic [CNT_WIDTH-1:0]  r_correct;
   logic [CNT_WIDTH-1:0]  r_mismatch;
   logic [ADDR_WIDTH-1:0] r_first_addr;
   logic                  r_first_valid;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_pass;

   logic                  w_start;
   logic                  w_last;
   logic                  w_match;
   logic                  w_bad;
   logic [CNT_WIDTH-1:0]  w_mismatch_next;

   assign w_start = (r_state == S_IDLE) && chk_run && !r_run_q;
   assign w_last  = (r_addr == (r_num - A_ONE));
   assign w_match = (res_chk_read_data == gold_chk_read_data);
   assign w_bad   = r_cmp_valid && !w_match;

   // Mismatch count including the compare happening this cycle; used so the
   // pass flag seen with chk_done already accounts for the drain compare.
   assign w_mismatch_next = w_bad ? (r_mismatch + C_ONE) : r_mismatch;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_state       <= S_IDLE;
         r_run_q       <= 1'b0;
         r_num         <= A_ZERO;
         r_addr        <= A_ZERO;
         r_cmp_valid   <= 1'b0;
         r_cmp_addr    <= A_ZERO;
         r_correct     <= C_ZERO;
         r_mismatch    <= C_ZERO;
         r_first_addr  <= A_ZERO;
         r_first_valid <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
      end else begin
         r_run_q     <= chk_run;
         r_done      <= 1'b0;
         r_cmp_valid <= 1'b0;

         // Compare stage: data returned for the address issued last cycle.
         if (r_cmp_valid) begin
            if (w_match) begin
               r_correct <= r_correct + C_ONE;
            end else begin
               r_mismatch <= r_mismatch + C_ONE;
               if (!r_first_valid) begin
                  r_first_valid <= 1'b1;
                  r_first_addr  <= r_cmp_addr;
               end
            end
         end

         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_num         <= chk_num_results;
                  r_addr        <= A_ZERO;
                  r_correct     <= C_ZERO;
                  r_mismatch    <= C_ZERO;
                  r_first_valid <= 1'b0;
                  r_first_addr  <= A_ZERO;
                  if (chk_num_results != A_ZERO) begin
                     r_state <= S_READ;
                     r_busy  <= 1'b1;
                     r_pass  <= 1'b0;
                  end else begin
                     // Nothing to compare: trivially passing check.
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_pass  <= 1'b1;
                  end
               end
            end
            S_READ: begin
               // Tag the address now on the bus so its data is compared next cycle.
               r_cmp_valid <= 1'b1;
               r_cmp_addr  <= r_addr;
               if (w_last) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_addr <= r_addr + A_ONE;
               end
            end
            S_DRAIN: begin
               r_state <= S_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_pass  <= (w_mismatch_next == C_ZERO);
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign chk_busy                 = r_busy;
   assign chk_done                 = r_done;
   assign chk_pass                 = r_pass;
   assign chk_res_read_address     = r_addr;
   assign chk_gold_read_address    = r_addr;
   assign chk_correct_count        = r_correct;
   assign chk_mismatch_count       = r_mismatch;
   assign chk_first_mismatch_addr  = r_first_addr;
   assign chk_first_mismatch_valid = r_first_valid;
   assign chk_dbg_state            = r_state;

endmodule
